neuron_controller: RTL and testbench

//  Consumes spike packets that the tick scheduler has released for the current tick.
//  Per packet: looks up the axon's crossbar row, then integrates a signed weight into each connected neuron's potential.
//  On every global tick rising edge: sweeps all neurons, emits a spike id for each neuron at/over threshold, and zeroes its potential.

---
 rtl/neuron_controller_pkg.sv | 33 +++
 rtl/neuron_controller_crossbar_ram.sv | 29 ++
 rtl/neuron_controller.sv | 170 +++++++++++++++++
 tb/tb_neuron_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_controller_pkg.sv
// Shared types and helpers for the neuron core controller: FSM states,
// packet field layout and the saturating potential adder.
package nsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INTEG,
    ST_FIRE
  } ctrl_state_e;

  // Packet layout: [7:0] duration, then axon index, then 2-bit axon type.
  localparam int PKT_DUR_W    = 8;
  localparam int PKT_AXON_LSB = PKT_DUR_W;
  localparam int PKT_TYPE_W   = 2;
  localparam int N_TYPES      = 1 << PKT_TYPE_W;

  // Adds w to pot and clamps the result to the signed range of 'width' bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] pot,
                                                 input logic signed [31:0] w,
                                                 input int                 width);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = pot + w;
    hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (width - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/neuron_controller_crossbar_ram.sv
// Crossbar connectivity store: one row per axon, one bit per neuron.
// Single write port, single read port with a registered (1-cycle) read.
module crossbar_ram #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM macros; software must load every row before use.
  always_ff @(posedge clk) begin
    if (i_we && (32'(i_waddr) < DEPTH)) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/neuron_controller.sv
// Neuron core controller: integrates released spike packets into membrane
// potentials via a crossbar row lookup, and sweeps for spikes on each tick.
module neuron_controller
  import nsc_pkg::*;
#(
  parameter  int N_COUNT     = 256,
  parameter  int N_AXON      = 256,
  parameter  int GRANULARITY = 4,
  parameter  int PKT_SIZE    = 32,
  parameter  int POT_W       = 16,
  parameter  int WEIGHT_W    = 8,
  parameter  int THRESHOLD   = 100,
  localparam int PKT_W       = PKT_SIZE - GRANULARITY,
  localparam int AXON_W      = $clog2(N_AXON),
  localparam int N_W         = $clog2(N_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [PKT_W-1:0]              pkt_in,
  input  logic                          pkt_valid,
  output logic                          dropped_c2r,
  input  logic [N_TYPES*WEIGHT_W-1:0]   weights,
  input  logic                          cfg_we,
  input  logic [AXON_W-1:0]             cfg_axon,
  input  logic [N_COUNT-1:0]            cfg_row,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [N_W-1:0]                spike_id,
  output logic                          busy
);

  localparam int             TYPE_LSB = PKT_AXON_LSB + AXON_W;
  localparam logic [N_W-1:0] LAST_N   = N_W'(N_COUNT - 1);

  ctrl_state_e               r_state;
  ctrl_state_e               w_state_nxt;
  logic                      r_tick_q;
  logic                      r_fire_pending;
  logic                      r_dropped;
  logic [PKT_TYPE_W-1:0]     r_type;
  logic [N_COUNT-1:0]        r_row;
  logic [N_W-1:0]            r_n;
  logic signed [POT_W-1:0]   r_pot [N_COUNT];

  logic [AXON_W-1:0]         w_axon;
  logic [PKT_TYPE_W-1:0]     w_type;
  logic                      w_axon_ok;
  logic                      w_accept;
  logic                      w_refuse;
  logic                      w_tick_edge;
  logic                      w_rd_en;
  logic                      w_clear_pending;
  logic                      w_fire;
  logic                      w_advance;
  logic                      w_last;
  logic [N_COUNT-1:0]        w_rd_data;
  logic signed [WEIGHT_W-1:0] w_weight;
  logic signed [31:0]        w_addend;
  logic signed [31:0]        w_sum;
  logic signed [POT_W-1:0]   w_sat;
  logic                      w_unused_pkt;

  // Packet decode; duration and reserved bits are not used by this block.
  assign w_axon       = pkt_in[PKT_AXON_LSB +: AXON_W];
  assign w_type       = pkt_in[TYPE_LSB +: PKT_TYPE_W];
  assign w_unused_pkt = ^{pkt_in[PKT_DUR_W-1:0], pkt_in[PKT_W-1:TYPE_LSB+PKT_TYPE_W]};
  assign w_axon_ok    = (32'(w_axon) < N_AXON);

  assign w_tick_edge  = tick & ~r_tick_q;
  assign w_accept     = pkt_valid && (r_state == ST_IDLE) && !r_fire_pending && w_axon_ok;
  assign w_refuse     = pkt_valid && !w_accept;

  // One adder serves both phases: INTEG adds the weight, FIRE subtracts the
  // threshold and only the sign of the clamped result is used.
  assign w_weight  = weights[32'(r_type)*WEIGHT_W +: WEIGHT_W];
  assign w_addend  = (r_state == ST_FIRE) ? -THRESHOLD : 32'(w_weight);
  assign w_sum     = sat_add(32'(r_pot[r_n]), w_addend, POT_W);
  assign w_sat     = w_sum[POT_W-1:0];
  assign w_fire    = (r_state == ST_FIRE) && !w_sat[POT_W-1];
  assign w_advance = !w_fire || spike_ready;
  assign w_last    = (r_n == LAST_N);

  crossbar_ram #(
    .DEPTH (N_AXON),
    .WIDTH (N_COUNT)
  ) u_xbar (
    .clk     (clk),
    .i_we    (cfg_we),
    .i_waddr (cfg_axon),
    .i_wdata (cfg_row),
    .i_re    (w_rd_en),
    .i_raddr (w_axon),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that skips an assignment would infer a latch.
    w_state_nxt     = r_state;
    w_rd_en         = 1'b0;
    w_clear_pending = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_fire_pending) begin
          w_state_nxt     = ST_FIRE;
          w_clear_pending = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_LOAD;
          w_rd_en     = 1'b1;
        end
      end
      ST_LOAD:  w_state_nxt = ST_INTEG;
      ST_INTEG: if (w_last) w_state_nxt = ST_IDLE;
      ST_FIRE:  if (w_advance && w_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_tick_q       <= 1'b0;
      r_fire_pending <= 1'b0;
      r_dropped      <= 1'b0;
      r_type         <= '0;
      r_row          <= '0;
      r_n            <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop see pre-edge values, independent of statement order.
      r_state   <= w_state_nxt;
      r_tick_q  <= tick;
      r_dropped <= w_refuse;
      // An edge arriving while a sweep is already owed merges into it.
      if (w_clear_pending) begin
        r_fire_pending <= 1'b0;
      end else if (w_tick_edge) begin
        r_fire_pending <= 1'b1;
      end
      if (w_accept) begin
        r_type <= w_type;
      end
      if (r_state == ST_LOAD) begin
        r_row <= w_rd_data;
      end
      case (r_state)
        ST_INTEG: r_n <= w_last ? '0 : r_n + N_W'(1);
        ST_FIRE:  if (w_advance) r_n <= w_last ? '0 : r_n + N_W'(1);
        default:  r_n <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COUNT; i++) begin
        r_pot[i] <= '0;
      end
    end else if ((r_state == ST_INTEG) && r_row[r_n]) begin
      r_pot[r_n] <= w_sat;
    end else if (w_fire && spike_ready) begin
      r_pot[r_n] <= '0;
    end
  end

  assign dropped_c2r = r_dropped;
  assign spike_valid = w_fire;
  assign spike_id    = (r_state == ST_FIRE) ? r_n : '0;
  assign busy        = (r_state != ST_IDLE) || r_fire_pending;

endmodule

// File: tb/tb_neuron_controller.sv
// Self-checking bench for neuron_controller: a potential model plus a spike
// scoreboard filled when ticks are driven and drained on each handshake.
module tb_neuron_controller;

  localparam int N_COUNT   = 32;
  localparam int N_AXON    = 24;
  localparam int PKT_W     = 28;
  localparam int AXON_W    = $clog2(N_AXON);
  localparam int N_W       = $clog2(N_COUNT);
  localparam int THRESHOLD = 100;

  logic               clk;
  logic               rst_n;
  logic               tick;
  logic [PKT_W-1:0]   pkt_in;
  logic               pkt_valid;
  logic               dropped_c2r;
  logic [31:0]        weights;
  logic               cfg_we;
  logic [AXON_W-1:0]  cfg_axon;
  logic [N_COUNT-1:0] cfg_row;
  logic               spike_valid;
  logic               spike_ready;
  logic [N_W-1:0]     spike_id;
  logic               busy;

  neuron_controller #(
    .N_COUNT (N_COUNT),
    .N_AXON  (N_AXON)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .pkt_in      (pkt_in),
    .pkt_valid   (pkt_valid),
    .dropped_c2r (dropped_c2r),
    .weights     (weights),
    .cfg_we      (cfg_we),
    .cfg_axon    (cfg_axon),
    .cfg_row     (cfg_row),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_id    (spike_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int drop_seen = 0;
  int m_drops = 0;
  int m_pot [N_COUNT];
  int m_w [4] = '{10, 127, -128, 33};
  logic [N_COUNT-1:0] m_row [N_AXON];
  int exp_q [$];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bsat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [PKT_W-1:0] mk_pkt(input int axon, input int typ);
    logic [PKT_W-1:0] p;
    p = '0;
    p[7:0] = 8'h5A;
    p[8 +: AXON_W] = AXON_W'(axon);
    p[8+AXON_W +: 2] = 2'(typ);
    return p;
  endfunction

  task automatic model_pkt(input int axon, input int typ);
    for (int n = 0; n < N_COUNT; n++)
      if (m_row[axon][n]) m_pot[n] = bsat(m_pot[n] + m_w[typ]);
  endtask

  task automatic model_tick();
    for (int n = 0; n < N_COUNT; n++)
      if (m_pot[n] >= THRESHOLD) begin
        exp_q.push_back(n);
        m_pot[n] = 0;
      end
  endtask

  task automatic wr_row(input int a, input logic [N_COUNT-1:0] r);
    @(posedge clk); #2;
    cfg_we = 1'b1; cfg_axon = AXON_W'(a); cfg_row = r;
    @(posedge clk); #2;
    cfg_we = 1'b0;
    m_row[a] = r;
  endtask

  task automatic send_raw(input int axon, input int typ);
    @(posedge clk); #2;
    pkt_in = mk_pkt(axon, typ); pkt_valid = 1'b1;
    @(posedge clk); #2;
    pkt_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check(tag, 1, 0);
  endtask

  task automatic send_pkt(input int axon, input int typ);
    send_raw(axon, typ);
    model_pkt(axon, typ);
    wait_idle("pkt_timeout");
  endtask

  task automatic check_pots(input string tag);
    int v;
    for (int i = 0; i < N_COUNT; i++) begin
      v = dut.r_pot[i];
      check($sformatf("%s_pot%0d", tag, i), v, m_pot[i]);
    end
  endtask

  task automatic do_tick();
    @(posedge clk); #2;
    tick = 1'b1;
    model_tick();
    @(posedge clk); #2;
    tick = 1'b0;
  endtask

  task automatic wait_spike(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spike_valid) return;
    end
    check(tag, 0, 1);
  endtask

  always @(negedge clk) begin
    if (dropped_c2r) drop_seen++;
    if (rst_n && spike_valid && spike_ready) begin
      if (exp_q.size() == 0) check("spike_extra", int'(spike_id), -1);
      else check("spike_id", int'(spike_id), exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0; tick = 1'b0; pkt_in = '0; pkt_valid = 1'b0;
    weights = {8'h21, 8'h80, 8'h7F, 8'h0A};
    cfg_we = 1'b0; cfg_axon = '0; cfg_row = '0; spike_ready = 1'b1;
    for (int i = 0; i < N_COUNT; i++) m_pot[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dropped", int'(dropped_c2r), 0);
    check("rst_spike_valid", int'(spike_valid), 0);
    check("rst_spike_id", int'(spike_id), 0);
    check("rst_busy", int'(busy), 0);
    check_pots("rst");
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int a = 0; a < N_AXON; a++) wr_row(a, '0);
    wr_row(5, N_COUNT'(1) << 3);
    wr_row(7, (N_COUNT'(1) << 10) | (N_COUNT'(1) << 20));
    wr_row(9, N_COUNT'(1) << 12);
    wr_row(23, N_COUNT'(1) << 31);

    // Single packet and its latency
    send_raw(5, 0);
    model_pkt(5, 0);
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("latency", cnt + 1, N_COUNT + 2);
    check_pots("t1");
    check("t1_drops", drop_seen, m_drops);

    // Threshold boundary, held spike, last-index neuron
    repeat (9) send_pkt(5, 0);
    repeat (3) send_pkt(7, 3);
    repeat (4) send_pkt(23, 3);
    send_pkt(9, 2);
    spike_ready = 1'b0;
    do_tick();
    wait_spike("t2_no_spike");
    check("t2_first_id", int'(spike_id), 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", int'(spike_valid), 1);
      check("t2_hold_id", int'(spike_id), 3);
    end
    @(posedge clk); #2;
    spike_ready = 1'b1;
    wait_idle("t2_timeout");
    check("t2_queue_left", exp_q.size(), 0);
    check_pots("t2");

    // Refusals: during INTEG and out-of-range axon
    send_raw(5, 0);
    model_pkt(5, 0);
    repeat (5) @(posedge clk);
    send_raw(9, 1);
    m_drops++;
    @(negedge clk);
    check("t3_drop_integ", int'(dropped_c2r), 1);
    @(negedge clk);
    check("t3_drop_pulse_end", int'(dropped_c2r), 0);
    wait_idle("t3_timeout");
    send_raw(30, 0);
    m_drops++;
    @(negedge clk);
    check("t3_drop_axon", int'(dropped_c2r), 1);
    check("t3_busy_after_bad_axon", int'(busy), 0);
    @(negedge clk);
    check_pots("t3");
    check("t3_drops", drop_seen, m_drops);

    // Saturation in both directions
    repeat (300) send_pkt(9, 1);
    check("t4_sat_hi", int'(dut.r_pot[12]), 32767);
    repeat (600) send_pkt(9, 2);
    check("t4_sat_lo", int'(dut.r_pot[12]), -32768);
    check_pots("t4");

    // Two tick edges during one INTEG merge into one sweep right after it
    send_raw(7, 3);
    model_pkt(7, 3);
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (cnt == 3) begin tick = 1'b1; model_tick(); end
      if (cnt == 6) tick = 1'b0;
      if (cnt == 9) tick = 1'b1;
      if (cnt == 12) tick = 1'b0;
    end
    check("t5_busy_span", cnt, 2 * N_COUNT + 2);
    check("t5_queue_left", exp_q.size(), 0);

    // Packet refused while a sweep is pending in IDLE
    @(posedge clk); #2;
    tick = 1'b1;
    model_tick();
    @(posedge clk); #2;
    pkt_in = mk_pkt(5, 0); pkt_valid = 1'b1;
    @(posedge clk); #2;
    pkt_valid = 1'b0; tick = 1'b0;
    m_drops++;
    @(negedge clk);
    check("t5_drop_pending", int'(dropped_c2r), 1);
    wait_idle("t5_timeout");
    check_pots("t5");
    check("t5_drops", drop_seen, m_drops);

    // Reset in the middle of a held spike
    repeat (9) send_pkt(5, 0);
    spike_ready = 1'b0;
    do_tick();
    wait_spike("t6_no_spike");
    check("t6_pre_valid", int'(spike_valid), 1);
    check("t6_pre_id", int'(spike_id), 3);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(spike_valid), 0);
    check("t6_rst_id", int'(spike_id), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_dropped", int'(dropped_c2r), 0);
    exp_q.delete();
    for (int i = 0; i < N_COUNT; i++) m_pot[i] = 0;
    check_pots("t6_rst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    spike_ready = 1'b1;
    send_pkt(5, 0);
    check_pots("t6_after");
    check("t6_drops", drop_seen, m_drops);
    check("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
